restador_display: RTL and testbench
===================================

# restador_display

Sequential output stage placed directly downstream of the 4-bit add/subtract unit. On a `valid` strobe it captures the unit's result (`resultado`, `signo`, `c_out`) and the operation select, converts the magnitude to BCD with a multi-cycle shift-add-3 engine, and drives a 4-digit multiplexed, active-low seven-segment display. The display holds the last converted value until the next accepted strobe.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit stays enabled; legal range ≥ 2.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `valid` input 1: sample strobe; accepted only in IDLE.
- `sel` input 1: 1 = subtract mode, 0 = add mode.
- `resultado` input 4: magnitude from the arithmetic unit.
- `signo` input 1: 1 = negative result (meaningful only when `sel`=1).
- `c_out` input 1: carry; used as bit 4 of the value in add mode.
- `busy` output 1: high while a conversion is in progress.
- `done` output 1: one-cycle pulse when display registers update.
- `seg` output 7: {g,f,e,d,c,b,a}, active-low.
- `an` output 4: digit enables, one-hot active-low; `an[0]` is the rightmost digit.

## Operation
- Value captured at acceptance:
  - `sel`=0: 5-bit unsigned `{c_out, resultado}`, range 0..30; negative flag = 0.
  - `sel`=1: `{1'b0, resultado}`, range 0..15; negative flag = `signo`.
- FSM states: IDLE, CONV, UPD.
  - IDLE → CONV when `valid`=1. Capture value and negative flag, clear the BCD register, load iteration count 5.
  - CONV: each cycle, first add 3 to any BCD nibble ≥ 5, then shift the {BCD, value} register left by 1. Decrement the count. Go to UPD after the 5th shift.
  - UPD: load display registers (tens, units, negative flag), pulse `done`, return to IDLE.
- `valid` asserted while not in IDLE is ignored; it is not queued.
- Display content:
  - Digit 0: units.
  - Digit 1: tens, or blank when tens = 0.
  - Digit 2: '-' (7'b0111111) when the negative flag is set, otherwise blank.
  - Digit 3: always blank (7'b1111111).
- Glyphs 0–9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
- Refresh:
  - Counter runs 0..REFRESH_DIV-1, width `$clog2(REFRESH_DIV)`.
  - On wrap, the digit index advances 0→1→2→3→0.
  - `an` and `seg` are registered from the digit index and display registers.
- The refresh counter and digit index run freely, independent of the FSM. A display update never resets them.

## Timing
- Reset (async assert, sync release):
  - FSM = IDLE; `busy`=0; `done`=0.
  - Refresh counter = 0; digit index = 0.
  - Display registers = tens 0, units 0, negative flag 0.
  - `an`=4'b1110; `seg`=7'b1000000.
- Latency:
  - `valid` is sampled at edge E0.
  - `busy`=1 from E0 to E6.
  - Shifts occur at E1..E5; UPD is entered at E5.
  - Display registers load at E6 and `done`=1 during the cycle after E6.
  - `busy` returns to 0 at E6, so a new `valid` can be accepted at E6+1.
- `seg`/`an` reflect new display registers at the next refresh register update after E6; no more than one cycle behind.
- Reset asserted mid-conversion aborts it. The display returns to its reset contents and no `done` pulse is produced.
- A digit-index wrap coinciding with the UPD edge is legal; the newly selected digit shows the new value one cycle later.

## Test plan
- Reset then idle with REFRESH_DIV=4 → `an` cycles 1110,1101,1011,0111 every 4 clocks; `seg` is 1000000, 1111111, 1111111, 1111111 for digits 0–3.
- `sel`=1, `signo`=1, `resultado`=7, `valid` pulse → `busy` high for 6 cycles, one `done` pulse. Digits: 0 = 1111000, 1 = blank, 2 = 0111111, 3 = blank.
- `sel`=0, `c_out`=1, `resultado`=4'b1110 (30) → digit 1 = 0110000 ('3'), digit 0 = 1000000 ('0'), digit 2 blank.
- `sel`=1, `signo`=0, `resultado`=15 → digit 1 = 1111001, digit 0 = 0010010, no minus sign. Then a second `valid` at E3 → ignored; exactly one `done`.
- `rst_n` pulled low at E3 of a conversion (previous display −7) → immediate reset outputs, no `done`. After release the display shows '0' until the next strobe.

Source files
------------

// File: rtl/restador_display_if.sv
// Signal bundle between the add/subtract unit (master) and the display stage (slave).
// Handshake: valid is sampled only while busy is low; a strobe seen while busy is dropped.
interface restador_display_if;
  logic       valid;
  logic       sel;
  logic [3:0] resultado;
  logic       signo;
  logic       c_out;
  logic       busy;
  logic       done;
  logic [6:0] seg;
  logic [3:0] an;
  logic [1:0] state_dbg;

  modport master (
    output valid, sel, resultado, signo, c_out,
    input  busy, done, seg, an, state_dbg
  );

  modport slave (
    input  valid, sel, resultado, signo, c_out,
    output busy, done, seg, an, state_dbg
  );
endinterface

// File: rtl/restador_display.sv
// Captures the add/subtract result, converts it to BCD with shift-add-3 and
// drives a 4-digit multiplexed active-low seven-segment display.
module restador_display #(
  parameter int REFRESH_DIV = 50000
) (
  input logic              clk,
  input logic              rst_n,
  restador_display_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    UPD  = 2'd2
  } state_t;

  localparam int              CW    = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]   RLAST = CW'(REFRESH_DIV - 1);
  localparam logic [6:0]      BLANK = 7'b1111111;
  localparam logic [6:0]      MINUS = 7'b0111111;

  state_t      state, state_nx;
  logic [12:0] shreg, shreg_nx, adj;   // {tens, units, value}
  logic [2:0]  iter, iter_nx;
  logic        neg, neg_nx;
  logic [3:0]  tens, units;
  logic        neg_disp;
  logic        done_r;
  logic [CW-1:0] rcnt;
  logic [1:0]  didx;
  logic [6:0]  digit_seg, seg_r;
  logic [3:0]  an_r;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = BLANK;
    endcase
  endfunction

  // Add-3 correction applied to both BCD nibbles before each shift
  always_comb begin
    adj = shreg;
    if (adj[8:5] >= 4'd5)  adj[8:5]  = adj[8:5] + 4'd3;
    if (adj[12:9] >= 4'd5) adj[12:9] = adj[12:9] + 4'd3;
  end

  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    iter_nx  = iter;
    neg_nx   = neg;
    case (state)
      IDLE: begin
        if (bus.valid) begin
          state_nx = CONV;
          shreg_nx = {8'd0, (bus.sel ? {1'b0, bus.resultado} : {bus.c_out, bus.resultado})};
          neg_nx   = bus.sel & bus.signo;
          iter_nx  = 3'd5;
        end
      end
      CONV: begin
        shreg_nx = adj << 1;
        iter_nx  = iter - 3'd1;
        if (iter == 3'd1) state_nx = UPD;
      end
      UPD:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      iter     <= '0;
      neg      <= 1'b0;
      tens     <= '0;
      units    <= '0;
      neg_disp <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state  <= state_nx;
      shreg  <= shreg_nx;
      iter   <= iter_nx;
      neg    <= neg_nx;
      done_r <= (state == UPD);
      if (state == UPD) begin
        tens     <= shreg[12:9];
        units    <= shreg[8:5];
        neg_disp <= neg;
      end
    end
  end

  always_comb begin
    digit_seg = BLANK;
    case (didx)
      2'd0:    digit_seg = glyph(units);
      2'd1:    digit_seg = (tens == 4'd0) ? BLANK : glyph(tens);
      2'd2:    digit_seg = neg_disp ? MINUS : BLANK;
      default: digit_seg = BLANK;
    endcase
  end

  // Refresh scan runs freely; display updates never disturb it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt  <= '0;
      didx  <= 2'd0;
      an_r  <= 4'b1110;
      seg_r <= 7'b1000000;
    end else begin
      if (rcnt == RLAST) begin
        rcnt <= '0;
        didx <= didx + 2'd1;
      end else begin
        rcnt <= rcnt + 1'b1;
      end
      an_r  <= ~(4'b0001 << didx);
      seg_r <= digit_seg;
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_r;
  assign bus.seg       = seg_r;
  assign bus.an        = an_r;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_restador_display.sv
// Bench for restador_display: directed scenarios plus random strobes, checked
// every cycle against a value-level model of the display stage.
module tb_restador_display;
  localparam int R = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  restador_display_if bus();
  restador_display #(.REFRESH_DIV(R)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;
  int done_cnt = 0;

  logic [6:0] glyph [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  logic [3:0] an_pat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  // Model: whole-number value, decimal digits by / and %
  int         m_phase, m_rcnt, m_didx, m_tens, m_units, m_val;
  bit         m_neg, m_cneg;
  logic       m_busy, m_done;
  logic [3:0] m_an;
  logic [6:0] m_seg;

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] model_digit(input int d);
    case (d)
      0:       return glyph[m_units];
      1:       return (m_tens == 0) ? 7'b1111111 : glyph[m_tens];
      2:       return m_neg ? 7'b0111111 : 7'b1111111;
      default: return 7'b1111111;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_rcnt = 0; m_didx = 0;
      m_tens = 0; m_units = 0; m_neg = 0; m_cneg = 0; m_val = 0;
      m_busy = 0; m_done = 0;
      m_an = 4'b1110; m_seg = 7'b1000000;
    end else begin
      m_an  = an_pat[m_didx];
      m_seg = model_digit(m_didx);
      m_rcnt++;
      if (m_rcnt == R) begin
        m_rcnt = 0;
        m_didx = (m_didx + 1) % 4;
      end
      m_done = 0;
      if (m_phase == 0) begin
        if (bus.valid) begin
          m_phase = 1;
          m_val   = bus.sel ? int'(bus.resultado) : int'(bus.c_out) * 16 + int'(bus.resultado);
          m_cneg  = bus.sel && bus.signo;
        end
      end else if (m_phase == 6) begin
        m_tens  = m_val / 10;
        m_units = m_val % 10;
        m_neg   = m_cneg;
        m_done  = 1;
        m_phase = 0;
      end else begin
        m_phase++;
      end
      m_busy = (m_phase != 0);
    end
  end

  always @(negedge clk) begin
    check("busy", {6'd0, bus.busy}, {6'd0, m_busy});
    check("done", {6'd0, bus.done}, {6'd0, m_done});
    check("an",   {3'd0, bus.an},   {3'd0, m_an});
    check("seg",  bus.seg, m_seg);
    busy_cnt += int'(bus.busy);
    done_cnt += int'(bus.done);
  end

  task automatic send(input logic s, input logic sg, input logic c, input logic [3:0] r);
    @(negedge clk); #2;
    bus.sel = s; bus.signo = sg; bus.c_out = c; bus.resultado = r; bus.valid = 1'b1;
    @(negedge clk); #2;
    bus.valid = 1'b0;
  endtask

  task automatic check_digit(input int d, input logic [6:0] exp, input string name);
    int n = 0;
    while (bus.an !== an_pat[d] && n < 20) begin
      @(negedge clk); #2;
      n++;
    end
    if (n == 20) begin
      checks++;
      errors++;
      $display("FAIL %s: digit %0d never selected (an=%b)", name, d, bus.an);
    end else begin
      check(name, bus.seg, exp);
    end
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.valid = 0; bus.sel = 0; bus.signo = 0; bus.c_out = 0; bus.resultado = 0;
    repeat (2) @(negedge clk);
    check("rst_an",   {3'd0, bus.an}, 7'b0001110);
    check("rst_seg",  bus.seg, 7'b1000000);
    check("rst_busy", {6'd0, bus.busy}, 7'd0);
    #2 rst_n = 1'b1;

    // Idle scan
    check_digit(0, 7'b1000000, "idle_d0");
    check_digit(1, 7'b1111111, "idle_d1");
    check_digit(2, 7'b1111111, "idle_d2");
    check_digit(3, 7'b1111111, "idle_d3");

    // -7
    busy_cnt = 0; done_cnt = 0;
    send(1, 1, 0, 4'd7);
    repeat (10) @(negedge clk); #2;
    check("m7_busy_cycles", 7'(busy_cnt), 7'd6);
    check("m7_done_pulses", 7'(done_cnt), 7'd1);
    check_digit(0, 7'b1111000, "m7_d0");
    check_digit(1, 7'b1111111, "m7_d1");
    check_digit(2, 7'b0111111, "m7_d2");
    check_digit(3, 7'b1111111, "m7_d3");

    // 30 in add mode
    send(0, 0, 1, 4'b1110);
    repeat (10) @(negedge clk); #2;
    check("model_tens30",  7'(m_tens), 7'd3);
    check("model_units30", 7'(m_units), 7'd0);
    check_digit(1, 7'b0110000, "p30_d1");
    check_digit(0, 7'b1000000, "p30_d0");
    check_digit(2, 7'b1111111, "p30_d2");

    // 15 with an ignored strobe at E3
    busy_cnt = 0; done_cnt = 0;
    send(1, 0, 0, 4'd15);
    repeat (2) @(negedge clk); #2;
    bus.sel = 0; bus.c_out = 1; bus.resultado = 4'd3; bus.valid = 1'b1;
    @(negedge clk); #2;
    bus.valid = 1'b0;
    repeat (10) @(negedge clk); #2;
    check("p15_done_pulses", 7'(done_cnt), 7'd1);
    check("p15_busy_cycles", 7'(busy_cnt), 7'd6);
    check_digit(1, 7'b1111001, "p15_d1");
    check_digit(0, 7'b0010010, "p15_d0");
    check_digit(2, 7'b1111111, "p15_d2");

    // Reset at E3 of a conversion following -7
    send(1, 1, 0, 4'd7);
    repeat (10) @(negedge clk); #2;
    busy_cnt = 0; done_cnt = 0;
    send(0, 0, 1, 4'd6);
    repeat (2) @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mrst_an",   {3'd0, bus.an}, 7'b0001110);
    check("mrst_seg",  bus.seg, 7'b1000000);
    check("mrst_busy", {6'd0, bus.busy}, 7'd0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    repeat (12) @(negedge clk); #2;
    check("mrst_done_pulses", 7'(done_cnt), 7'd0);
    check_digit(0, 7'b1000000, "mrst_d0");
    check_digit(1, 7'b1111111, "mrst_d1");
    check_digit(2, 7'b1111111, "mrst_d2");

    // Random strobes, some landing while busy
    for (int i = 0; i < 300; i++) begin
      logic s, sg, c;
      logic [3:0] r;
      repeat ($urandom_range(0, 8)) @(negedge clk);
      s  = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      c  = 1'($urandom_range(0, 1));
      r  = 4'($urandom_range(0, 15));
      if (!s && c && r == 4'd15) r = 4'd14;
      send(s, sg, c, r);
    end
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
